prog_loader: RTL

//  Boot-time program loader sitting upstream of the cpu core and in front of its MEMORY port.

---
 rtl/prog_loader_pkg.sv | 31 +++
 rtl/byte_timer.sv | 30 +++
 rtl/prog_loader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types for the boot-time program loader.
// State encodings are one-hot; LOAD_MASK marks the states that belong to a frame in flight.
package prog_loader_pkg;

    localparam logic [7:0] SYNC_DEF = 8'hA5;

    localparam int I_IDLE    = 0;
    localparam int I_ADDR_LO = 1;
    localparam int I_ADDR_HI = 2;
    localparam int I_LEN_LO  = 3;
    localparam int I_LEN_HI  = 4;
    localparam int I_DATA    = 5;
    localparam int I_CSUM    = 6;
    localparam int I_RUN     = 7;
    localparam int I_ERROR   = 8;

    typedef enum logic [8:0] {
        ST_IDLE    = 9'b0_0000_0001,
        ST_ADDR_LO = 9'b0_0000_0010,
        ST_ADDR_HI = 9'b0_0000_0100,
        ST_LEN_LO  = 9'b0_0000_1000,
        ST_LEN_HI  = 9'b0_0001_0000,
        ST_DATA    = 9'b0_0010_0000,
        ST_CSUM    = 9'b0_0100_0000,
        ST_RUN     = 9'b0_1000_0000,
        ST_ERROR   = 9'b1_0000_0000
    } state_e;

    localparam logic [8:0] LOAD_MASK = 9'b0_0111_1110;

endpackage

// File: rtl/byte_timer.sv
// Idle-cycle counter between frame bytes.
// expire pulses on the last allowed idle cycle; TIMEOUT of zero disables it.
module byte_timer #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic CLK,
    input  logic R,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [15:0] LAST = TIMEOUT - 16'd1;

    logic [15:0] cnt;

    // A transfer in the expiring cycle wins over the timeout.
    assign expire = (TIMEOUT != 16'd0) && en && !clr && (cnt == LAST);

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: writes a framed byte stream into memory, checks the sum,
// then releases the cpu and hands it the memory port.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_DEF,
    parameter bit          RELOAD_EN = 1'b1,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic        CLK,
    input  logic        R,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_we,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err
);

    state_e      state;
    logic [15:0] ptr;
    logic [15:0] len;
    logic [7:0]  sum;
    logic [7:0]  sum_nxt;
    logic        xfer;
    logic        is_sync;
    logic        loading;
    logic        expire;

    assign rx_ready = !(state == ST_RUN && !RELOAD_EN);
    assign xfer     = rx_valid && rx_ready;
    assign is_sync  = (rx_data == SYNC_BYTE);
    assign loading  = |(state & LOAD_MASK);
    assign sum_nxt  = sum + rx_data;

    byte_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK    (CLK),
        .R      (R),
        .clr    (xfer),
        .en     (loading),
        .expire (expire)
    );

    // The cpu owns the port only in RUN, and only once its reset has dropped.
    always_comb begin
        mem_addr = ptr;
        mem_data = rx_data;
        mem_we   = xfer && (state == ST_DATA);
        if (state == ST_RUN) begin
            mem_addr = cpu_addr;
            mem_data = cpu_data;
            mem_we   = cpu_we && !cpu_rst;
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            len       <= '0;
            sum       <= '0;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            if (state == ST_RUN) begin
                cpu_rst <= 1'b0;
            end
            if (loading && xfer) begin
                sum <= sum_nxt;
            end
            if (expire) begin
                state    <= ST_ERROR;
                load_err <= 1'b1;
            end else if (xfer) begin
                unique case (1'b1)
                    state[I_IDLE], state[I_RUN], state[I_ERROR]: begin
                        if (is_sync) begin
                            state     <= ST_ADDR_LO;
                            sum       <= '0;
                            cpu_rst   <= 1'b1;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                        end
                    end
                    state[I_ADDR_LO]: begin
                        ptr[7:0] <= rx_data;
                        state    <= ST_ADDR_HI;
                    end
                    state[I_ADDR_HI]: begin
                        ptr[15:8] <= rx_data;
                        state     <= ST_LEN_LO;
                    end
                    state[I_LEN_LO]: begin
                        len[7:0] <= rx_data;
                        state    <= ST_LEN_HI;
                    end
                    state[I_LEN_HI]: begin
                        len[15:8] <= rx_data;
                        state     <= ({rx_data, len[7:0]} == 16'd0) ?
                                     ST_CSUM : ST_DATA;
                    end
                    state[I_DATA]: begin
                        ptr <= ptr + 16'd1;
                        len <= len - 16'd1;
                        if (len == 16'd1) begin
                            state <= ST_CSUM;
                        end
                    end
                    state[I_CSUM]: begin
                        if (sum_nxt == 8'd0) begin
                            state     <= ST_RUN;
                            load_done <= 1'b1;
                        end else begin
                            state    <= ST_ERROR;
                            load_err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
